mxv_seq_ctl: RTL and testbench
==============================

Name: mxv_seq_ctl

Overview:
Sequencer for one matrix-times-vector transaction, started once the length-field controller has locked a valid dimension N. It loads N*N matrix bytes and then N vector bytes from the UART receiver into the operand memories, acknowledging each byte. It then runs the row datapath once per row and hands each row result to the transmitter. When the transaction is complete, it pulses UNLOCKME to release the length-field controller.

Parameters:
MAX_N, 8, largest supported dimension
N_W, 4, width of LENGTH and ROW_IDX; must hold MAX_N
ADDR_W, 6, operand memory address width; must hold MAX_N*MAX_N-1
DATA_W, 8, UART byte width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
RXINT  in  1  byte-available level from UART receiver; held until CLEARFLAG
RX_DATA  in  DATA_W  received byte; valid while RXINT=1
LOCKEDFLAG  in  1  length-field controller holds a valid N
LENGTH  in  N_W  dimension N; valid while LOCKEDFLAG=1
ROW_DONE  in  1  one-cycle pulse: row datapath finished
TX_DONE  in  1  one-cycle pulse: transmitter finished sending the row result
CLEARFLAG  out  1  one-cycle pulse that clears RXINT
MAT_WE  out  1  matrix memory write strobe
VEC_WE  out  1  vector memory write strobe
WR_ADDR  out  ADDR_W  write address
WR_DATA  out  DATA_W  write data
ROW_START  out  1  one-cycle pulse: start row ROW_IDX
ROW_IDX  out  N_W  current row index
TX_START  out  1  one-cycle pulse: transmit current row result
UNLOCKME  out  1  one-cycle pulse releasing the length-field controller
ERRFLAG  out  1  one-cycle pulse: LENGTH was illegal
BUSY  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; N, address counter, column counter, row counter and the WR_DATA register all cleared. Every output is 0.
- Strobe outputs are decoded from the registered state only; they are never combinational on inputs.
- WR_ADDR and ROW_IDX come directly from the counters. WR_DATA is a register that captures RX_DATA on each *_WAIT -> *_WR transition.

State transitions:
- IDLE: if LOCKEDFLAG=1, latch N<=LENGTH and go to CHECK.
- CHECK: if N=0 or N>MAX_N, go to ERR. Otherwise clear the counters and go to MAT_WAIT.
- MAT_WAIT: if RXINT=1, go to MAT_WR.
- MAT_WR: MAT_WE=1 and CLEARFLAG=1 for exactly one cycle.
  - If addr=N*N-1, clear addr and go to VEC_WAIT.
  - Otherwise addr+1 and go to MAT_WAIT.
  - Matrix memory is row-major, so addr=row*N+col. Track a column counter for end-of-matrix detection; do not use a multiplier.
- VEC_WAIT: if RXINT=1, go to VEC_WR.
- VEC_WR: VEC_WE=1 and CLEARFLAG=1.
  - If addr=N-1, clear row and go to ROW_GO.
  - Otherwise addr+1 and go to VEC_WAIT.
- ROW_GO: ROW_START=1 for one cycle, then ROW_WAIT.
- ROW_WAIT: on ROW_DONE=1, go to TX_GO.
- TX_GO: TX_START=1 for one cycle, then TX_WAIT.
- TX_WAIT: on TX_DONE=1:
  - if row=N-1, go to RELEASE;
  - otherwise row+1 and go to ROW_GO.
- RELEASE: UNLOCKME=1 for one cycle, then IDLE.
- ERR: ERRFLAG=1 and UNLOCKME=1 for one cycle, then IDLE. No memory writes and no CLEARFLAG occur on this path.
- Illegal state encodings go to IDLE.

Boundaries and timing:
- Minimum byte spacing is 2 cycles: WAIT then WR. RXINT held high for back-to-back bytes is legal; the next byte is taken on the cycle after WR.
- N=1: exactly one MAT_WR, one VEC_WR, one ROW_GO/TX_GO pair.
- N=MAX_N: last matrix address is MAX_N*MAX_N-1 with no overflow; address width checks hold at this value.
- Strobes in the wrong state are ignored:
  - ROW_DONE outside ROW_WAIT;
  - TX_DONE outside TX_WAIT;
  - RXINT outside the *_WAIT states.
- LOCKEDFLAG falling mid-transaction is ignored; N is latched.
- After RELEASE, the length-field controller leaves LOCKED on the same edge at which this block enters IDLE, so IDLE sees LOCKEDFLAG=0 and does not restart.
- Reset asserted mid-transaction returns the block to IDLE immediately with all outputs 0. No partial strobe is allowed.
- Latency:
  - LOCKEDFLAG to first possible MAT_WE: 3 cycles.
  - ROW_DONE to TX_START: 1 cycle.
  - TX_DONE on the last row to UNLOCKME: 1 cycle.

Test Plan:
- N=2, matrix bytes 0x01..0x04, vector 0x05,0x06, each RXINT held until CLEARFLAG -> MAT_WE at addr 0,1,2,3 with data 0x01..0x04; VEC_WE at addr 0,1 with data 0x05,0x06; 6 CLEARFLAG pulses total.
- Same load, then ROW_DONE 4 cycles after each ROW_START and TX_DONE 10 cycles after each TX_START -> ROW_IDX 0 then 1; exactly 2 TX_START pulses; UNLOCKME 1 cycle after the second TX_DONE; BUSY=0 on the next cycle.
- LENGTH=0, and separately LENGTH=9 -> ERRFLAG and UNLOCKME in the same cycle, 2 cycles after LOCKEDFLAG; no MAT_WE, VEC_WE or CLEARFLAG.
- N=8 with RXINT held continuously -> 64 MAT_WE pulses at addr 0..63, every other cycle; then 8 VEC_WE pulses at addr 0..7.
- Reset pulsed after the 3rd matrix byte of N=2 -> all outputs 0 and state IDLE; a new LOCKEDFLAG restarts writing at addr 0.
- Spurious ROW_DONE or TX_DONE during the load phases, and RXINT during ROW_WAIT -> no state change and no extra strobes.

Source files
------------

// File: rtl/mxv_seq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : mxv_seq_ctl
// Purpose  : Sequencer for one matrix-times-vector transaction. It loads N*N
//            matrix bytes and then N vector bytes from the UART receiver into
//            the operand memories. It then runs the row datapath and the
//            transmitter once per row. At the end it releases the length-field
//            controller.
// Ports    : clk, reset (async active-low)
//            RXINT/RX_DATA/CLEARFLAG  - UART receive handshake
//            LOCKEDFLAG/LENGTH/UNLOCKME/ERRFLAG - length-field controller
//            MAT_WE/VEC_WE/WR_ADDR/WR_DATA - operand memory write port
//            ROW_START/ROW_IDX/ROW_DONE - row datapath control
//            TX_START/TX_DONE - transmitter control
//            BUSY - high whenever the sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mxv_seq_ctl #(
    parameter int MAX_N  = 8,
    parameter int N_W    = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RXINT,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              LOCKEDFLAG,
    input  logic [N_W-1:0]    LENGTH,
    input  logic              ROW_DONE,
    input  logic              TX_DONE,
    output logic              CLEARFLAG,
    output logic              MAT_WE,
    output logic              VEC_WE,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              ROW_START,
    output logic [N_W-1:0]    ROW_IDX,
    output logic              TX_START,
    output logic              UNLOCKME,
    output logic              ERRFLAG,
    output logic              BUSY
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_CHECK    = 4'd1;
    localparam logic [3:0] S_MAT_WAIT = 4'd2;
    localparam logic [3:0] S_MAT_WR   = 4'd3;
    localparam logic [3:0] S_VEC_WAIT = 4'd4;
    localparam logic [3:0] S_VEC_WR   = 4'd5;
    localparam logic [3:0] S_ROW_GO   = 4'd6;
    localparam logic [3:0] S_ROW_WAIT = 4'd7;
    localparam logic [3:0] S_TX_GO    = 4'd8;
    localparam logic [3:0] S_TX_WAIT  = 4'd9;
    localparam logic [3:0] S_RELEASE  = 4'd10;
    localparam logic [3:0] S_ERR      = 4'd11;

    localparam logic [N_W-1:0]    c_max_n    = N_W'(MAX_N);
    localparam logic [N_W-1:0]    c_n_one    = N_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [3:0]        r_state;
    logic [N_W-1:0]    r_n;
    logic [N_W-1:0]    r_col;
    logic [N_W-1:0]    r_row;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic [N_W-1:0]    w_n_m1;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_vec_last;

    // The column/row pair walks the row-major matrix alongside the linear
    // address, so end-of-matrix is (row, col) = (N-1, N-1) and no N*N
    // product is ever formed.
    assign w_n_m1     = r_n - c_n_one;
    assign w_col_last = (r_col == w_n_m1);
    assign w_row_last = (r_row == w_n_m1);
    assign w_vec_last = (r_addr == ADDR_W'(w_n_m1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_wr_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (LOCKEDFLAG) begin
                        r_n     <= LENGTH;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if ((r_n == '0) || (r_n > c_max_n)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= S_MAT_WAIT;
                    end
                end
                S_MAT_WAIT: begin
                    if (RXINT) begin
                        r_wr_data <= RX_DATA;
                        r_state   <= S_MAT_WR;
                    end
                end
                S_MAT_WR: begin
                    if (w_col_last && w_row_last) begin
                        r_addr  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= S_VEC_WAIT;
                    end else begin
                        r_addr <= r_addr + c_addr_one;
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + c_n_one;
                        end else begin
                            r_col <= r_col + c_n_one;
                        end
                        r_state <= S_MAT_WAIT;
                    end
                end
                S_VEC_WAIT: begin
                    if (RXINT) begin
                        r_wr_data <= RX_DATA;
                        r_state   <= S_VEC_WR;
                    end
                end
                S_VEC_WR: begin
                    if (w_vec_last) begin
                        r_row   <= '0;
                        r_state <= S_ROW_GO;
                    end else begin
                        r_addr  <= r_addr + c_addr_one;
                        r_state <= S_VEC_WAIT;
                    end
                end
                S_ROW_GO: begin
                    r_state <= S_ROW_WAIT;
                end
                S_ROW_WAIT: begin
                    if (ROW_DONE) begin
                        r_state <= S_TX_GO;
                    end
                end
                S_TX_GO: begin
                    r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (TX_DONE) begin
                        if (w_row_last) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_row   <= r_row + c_n_one;
                            r_state <= S_ROW_GO;
                        end
                    end
                end
                S_RELEASE: begin
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes depend only on the registered state, so they are glitch-free
    // and cannot follow the inputs combinationally.
    assign CLEARFLAG = (r_state == S_MAT_WR) || (r_state == S_VEC_WR);
    assign MAT_WE    = (r_state == S_MAT_WR);
    assign VEC_WE    = (r_state == S_VEC_WR);
    assign ROW_START = (r_state == S_ROW_GO);
    assign TX_START  = (r_state == S_TX_GO);
    assign UNLOCKME  = (r_state == S_RELEASE) || (r_state == S_ERR);
    assign ERRFLAG   = (r_state == S_ERR);
    assign BUSY      = (r_state != S_IDLE);
    assign WR_ADDR   = r_addr;
    assign WR_DATA   = r_wr_data;
    assign ROW_IDX   = r_row;

endmodule
`default_nettype wire

// File: tb/tb_mxv_seq_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxv_seq_ctl
// Purpose  : Self-checking bench for mxv_seq_ctl. It uses randomised byte
//            streams, gaps and handshake delays. Observed strobes are logged
//            and compared against the transaction that should result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxv_seq_ctl;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       RXINT      = 1'b0;
    logic [7:0] RX_DATA    = 8'd0;
    logic       LOCKEDFLAG = 1'b0;
    logic [3:0] LENGTH     = 4'd0;
    logic       ROW_DONE   = 1'b0;
    logic       TX_DONE    = 1'b0;

    logic       CLEARFLAG, MAT_WE, VEC_WE, ROW_START, TX_START;
    logic       UNLOCKME, ERRFLAG, BUSY;
    logic [5:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic [3:0] ROW_IDX;
    logic [25:0] outs;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [13:0] mat_q[$];
    logic [13:0] vec_q[$];
    int          mat_c[$];
    int          vec_c[$];
    int          row_q[$];
    int          tx_q[$];
    int          unl_c[$];
    int          err_c[$];
    int          clr_cnt = 0;

    mxv_seq_ctl #(.MAX_N(8), .N_W(4), .ADDR_W(6), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .RXINT      (RXINT),
        .RX_DATA    (RX_DATA),
        .LOCKEDFLAG (LOCKEDFLAG),
        .LENGTH     (LENGTH),
        .ROW_DONE   (ROW_DONE),
        .TX_DONE    (TX_DONE),
        .CLEARFLAG  (CLEARFLAG),
        .MAT_WE     (MAT_WE),
        .VEC_WE     (VEC_WE),
        .WR_ADDR    (WR_ADDR),
        .WR_DATA    (WR_DATA),
        .ROW_START  (ROW_START),
        .ROW_IDX    (ROW_IDX),
        .TX_START   (TX_START),
        .UNLOCKME   (UNLOCKME),
        .ERRFLAG    (ERRFLAG),
        .BUSY       (BUSY)
    );

    assign outs = {CLEARFLAG, MAT_WE, VEC_WE, WR_ADDR, WR_DATA, ROW_START,
                   ROW_IDX, TX_START, UNLOCKME, ERRFLAG, BUSY};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled on the falling edge, half a cycle after outputs settle.
    always @(negedge clk) begin
        if (MAT_WE)    begin mat_q.push_back({WR_ADDR, WR_DATA}); mat_c.push_back(cyc); end
        if (VEC_WE)    begin vec_q.push_back({WR_ADDR, WR_DATA}); vec_c.push_back(cyc); end
        if (CLEARFLAG) clr_cnt = clr_cnt + 1;
        if (ROW_START) row_q.push_back(int'(ROW_IDX));
        if (TX_START)  tx_q.push_back(int'(ROW_IDX));
        if (UNLOCKME)  unl_c.push_back(cyc);
        if (ERRFLAG)   err_c.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        mat_q.delete(); vec_q.delete(); mat_c.delete(); vec_c.delete();
        row_q.delete(); tx_q.delete(); unl_c.delete(); err_c.delete();
        clr_cnt = 0;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        RXINT = 1'b0; LOCKEDFLAG = 1'b0; ROW_DONE = 1'b0; TX_DONE = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // One full transaction: drive, then compare the log with the expected
    // sequence (matrix bytes to addr 0..N*N-1, vector bytes to 0..N-1,
    // rows 0..N-1, exactly one release).
    task automatic run_txn(input int n, input bit fixed, input bit hold,
                           input bit drop_lock, input int rd, input int td,
                           input bit spur, input int abort_at, input string tag);
        logic [7:0]  b[$];
        logic [13:0] exp;
        int nb, t, lock_cyc, g;
        nb = n * n + n;
        for (int k = 0; k < nb; k++)
            b.push_back(fixed ? 8'(k + 1) : 8'($urandom_range(0, 255)));
        @(negedge clk);
        clear_logs();
        LENGTH = 4'(n); LOCKEDFLAG = 1'b1; lock_cyc = cyc;
        for (int k = 0; k < nb; k++) begin
            RX_DATA = b[k]; RXINT = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!CLEARFLAG && t < 60);
            if (!CLEARFLAG) begin
                n_vec++; n_err++;
                $display("FAIL %s clearflag_timeout: byte %0d got no CLEARFLAG, want pulse", tag, k);
                hard_reset();
                return;
            end
            if (k == 0 && drop_lock) LOCKEDFLAG = 1'b0;
            if (k + 1 == abort_at) begin
                #2 reset = 1'b0;
                #1;
                n_vec++;
                if (outs !== 26'd0) begin
                    n_err++;
                    $display("FAIL %s reset_mid_outputs: got %h want 0", tag, outs);
                end
                RXINT = 1'b0; LOCKEDFLAG = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (k == nb - 1) begin
                RXINT = 1'b0;
            end else if (!hold) begin
                RXINT = 1'b0;
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    if (spur) begin ROW_DONE = 1'b1; TX_DONE = 1'b1; end
                    @(negedge clk);
                    ROW_DONE = 1'b0; TX_DONE = 1'b0;
                end
            end
        end

        for (int r = 0; r < n; r++) begin
            t = 0;
            while (!ROW_START && t < 60) begin @(negedge clk); t++; end
            if (!ROW_START) begin
                n_vec++; n_err++;
                $display("FAIL %s row_start_timeout: row %0d got no ROW_START, want pulse", tag, r);
                hard_reset();
                return;
            end
            for (int j = 0; j < rd; j++) begin
                @(negedge clk);
                if (spur && j == 0 && rd >= 2) begin
                    RXINT = 1'b1; RX_DATA = 8'($urandom_range(0, 255)); TX_DONE = 1'b1;
                end else begin
                    RXINT = 1'b0; TX_DONE = 1'b0;
                end
            end
            RXINT = 1'b0; TX_DONE = 1'b0;
            ROW_DONE = 1'b1;
            @(negedge clk);
            ROW_DONE = 1'b0;
            n_vec++;
            if (TX_START !== 1'b1) begin
                n_err++;
                $display("FAIL %s tx_start_latency: row %0d TX_START=%b want 1", tag, r, TX_START);
            end
            for (int j = 0; j < td; j++) begin
                @(negedge clk);
                ROW_DONE = (spur && j == 0 && td >= 2);
            end
            ROW_DONE = 1'b0;
            TX_DONE = 1'b1;
            @(negedge clk);
            TX_DONE = 1'b0;
            if (r == n - 1) begin
                n_vec++;
                if (UNLOCKME !== 1'b1) begin
                    n_err++;
                    $display("FAIL %s unlock_latency: UNLOCKME=%b want 1", tag, UNLOCKME);
                end
                LOCKEDFLAG = 1'b0;
                @(negedge clk);
                n_vec++;
                if (BUSY !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s busy_after_release: BUSY=%b want 0", tag, BUSY);
                end
            end
        end
        repeat (2) @(negedge clk);

        n_vec++;
        if (mat_q.size() != n * n) begin
            n_err++;
            $display("FAIL %s mat_count: got %0d want %0d", tag, mat_q.size(), n * n);
        end
        for (int k = 0; k < mat_q.size() && k < n * n; k++) begin
            exp = {6'(k), b[k]};
            n_vec++;
            if (mat_q[k] !== exp) begin
                n_err++;
                $display("FAIL %s mat_write[%0d]: got addr/data %h want %h", tag, k, mat_q[k], exp);
            end
        end
        if (mat_c.size() > 0) begin
            n_vec++;
            if (mat_c[0] - lock_cyc != 3) begin
                n_err++;
                $display("FAIL %s first_mat_latency: got %0d want 3", tag, mat_c[0] - lock_cyc);
            end
        end
        n_vec++;
        if (vec_q.size() != n) begin
            n_err++;
            $display("FAIL %s vec_count: got %0d want %0d", tag, vec_q.size(), n);
        end
        for (int k = 0; k < vec_q.size() && k < n; k++) begin
            exp = {6'(k), b[n * n + k]};
            n_vec++;
            if (vec_q[k] !== exp) begin
                n_err++;
                $display("FAIL %s vec_write[%0d]: got addr/data %h want %h", tag, k, vec_q[k], exp);
            end
        end
        if (hold) begin
            for (int k = 1; k < mat_c.size(); k++) begin
                n_vec++;
                if (mat_c[k] - mat_c[k-1] != 2) begin
                    n_err++;
                    $display("FAIL %s mat_spacing[%0d]: got %0d want 2", tag, k, mat_c[k] - mat_c[k-1]);
                end
            end
            if (vec_c.size() > 0 && mat_c.size() > 0) begin
                n_vec++;
                if (vec_c[0] - mat_c[mat_c.size()-1] != 2) begin
                    n_err++;
                    $display("FAIL %s mat_to_vec_spacing: got %0d want 2", tag,
                             vec_c[0] - mat_c[mat_c.size()-1]);
                end
            end
        end
        n_vec++;
        if (clr_cnt != nb) begin
            n_err++;
            $display("FAIL %s clearflag_count: got %0d want %0d", tag, clr_cnt, nb);
        end
        n_vec++;
        if (row_q.size() != n || tx_q.size() != n) begin
            n_err++;
            $display("FAIL %s row_tx_count: got %0d/%0d want %0d/%0d", tag,
                     row_q.size(), tx_q.size(), n, n);
        end
        for (int k = 0; k < row_q.size() && k < tx_q.size() && k < n; k++) begin
            n_vec++;
            if (row_q[k] != k || tx_q[k] != k) begin
                n_err++;
                $display("FAIL %s row_idx[%0d]: got start %0d tx %0d want %0d", tag, k, row_q[k], tx_q[k], k);
            end
        end
        n_vec++;
        if (unl_c.size() != 1 || err_c.size() != 0) begin
            n_err++;
            $display("FAIL %s release_count: got unlock %0d err %0d want 1 0", tag, unl_c.size(), err_c.size());
        end
    endtask

    task automatic illegal_len(input logic [3:0] len);
        int t, lock_cyc;
        @(negedge clk);
        clear_logs();
        LENGTH = len; LOCKEDFLAG = 1'b1; RXINT = 1'b1; RX_DATA = 8'hA5; lock_cyc = cyc;
        t = 0;
        while (!ERRFLAG && t < 20) begin @(negedge clk); t++; end
        n_vec++;
        if (!ERRFLAG) begin
            n_err++;
            $display("FAIL illegal_len_%0d errflag_timeout: got 0 want pulse", len);
        end else begin
            n_vec++;
            if (cyc - lock_cyc != 2) begin
                n_err++;
                $display("FAIL illegal_len_%0d err_latency: got %0d want 2", len, cyc - lock_cyc);
            end
            n_vec++;
            if (UNLOCKME !== 1'b1) begin
                n_err++;
                $display("FAIL illegal_len_%0d unlock_with_err: got %b want 1", len, UNLOCKME);
            end
        end
        LOCKEDFLAG = 1'b0; RXINT = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (mat_q.size() + vec_q.size() + clr_cnt != 0) begin
            n_err++;
            $display("FAIL illegal_len_%0d writes: got %0d mat %0d vec %0d clr want 0",
                     len, mat_q.size(), vec_q.size(), clr_cnt);
        end
        n_vec++;
        if (BUSY !== 1'b0 || err_c.size() != 1 || unl_c.size() != 1) begin
            n_err++;
            $display("FAIL illegal_len_%0d after_err: got busy %b err %0d unlock %0d want 0 1 1",
                     len, BUSY, err_c.size(), unl_c.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (outs !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if (outs !== 26'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %h want 0", outs);
        end
    endtask

    task automatic test_n2_load();
        run_txn(2, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, -1, "n2_load");
    endtask

    task automatic test_n2_rows();
        run_txn(2, 1'b1, 1'b0, 1'b0, 4, 10, 1'b0, -1, "n2_rows");
    endtask

    task automatic test_illegal_length();
        illegal_len(4'd0);
        illegal_len(4'd9);
        illegal_len(4'($urandom_range(10, 15)));
    endtask

    task automatic test_max_n();
        run_txn(8, 1'b0, 1'b1, 1'b1, 2, 3, 1'b0, -1, "max_n");
    endtask

    task automatic test_n1();
        run_txn(1, 1'b0, 1'b0, 1'b0, 2, 2, 1'b0, -1, "n1");
    endtask

    task automatic test_reset_mid();
        run_txn(2, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 3, "reset_mid");
        run_txn(2, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0, -1, "after_reset_mid");
    endtask

    task automatic test_spurious();
        run_txn(3, 1'b0, 1'b0, 1'b0, 3, 4, 1'b1, -1, "spurious");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_txn($urandom_range(1, 8), 1'b0, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(1, 6),
                    $urandom_range(1, 12), 1'($urandom_range(0, 1)), -1, "random");
    endtask

    initial begin
        test_reset();
        test_n2_load();
        test_n2_rows();
        test_illegal_length();
        test_max_n();
        test_n1();
        test_reset_mid();
        test_spurious();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
